// File: rtl/lsu_misalign.sv
// Misaligned load/store sequencer: aligned accesses pass straight through, misaligned
// halfword/word accesses are stalled and split into byte accesses. Build option: MISALIGN_TRAP_EN.
module lsu_misalign #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [2:0]       req_ctrl,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             stall,
  output logic [31:0]      rdata,
  output logic             dm_we,
  output logic [2:0]       dm_ctrl,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  input  logic [31:0]      dm_rdata,
  output logic [CNT_W-1:0] misalign_cnt
`ifdef MISALIGN_TRAP_EN
  ,
  output logic             misalign_exc
`endif
);

  typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;

  state_t           r_state;
  logic [1:0]       r_idx;
  logic [31:0]      r_buf;
  logic [CNT_W-1:0] r_cnt;

  logic        w_half;
  logic        w_word;
  logic        w_mis;
  logic [2:0]  w_byte_ctrl;
  logic [31:0] w_asm;

  assign w_half      = (req_ctrl[1:0] == 2'b01);
  assign w_word      = (req_ctrl == 3'b010);
  assign w_mis       = req_valid & ((w_half & req_addr[0]) | (w_word & (req_addr[1:0] != 2'b00)));
  assign w_byte_ctrl = req_we ? 3'b000 : 3'b100;
  assign misalign_cnt = r_cnt;

  // Reassemble split load bytes with the extension the original funct3 asked for
  always_comb begin
    case (req_ctrl)
      3'b001:  w_asm = {{16{r_buf[15]}}, r_buf[15:0]};
      3'b101:  w_asm = {16'h0000, r_buf[15:0]};
      default: w_asm = r_buf;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    dm_we    = req_valid & req_we;
    dm_ctrl  = req_ctrl;
    dm_addr  = req_addr;
    dm_wdata = req_wdata;
    rdata    = dm_rdata;
`ifdef MISALIGN_TRAP_EN
    misalign_exc = w_mis;
    if (w_mis) begin
      dm_we = 1'b0;
      rdata = 32'h0;
    end
`else
    case (r_state)
      IDLE: begin
        if (w_mis) begin
          stall    = 1'b1;
          dm_ctrl  = w_byte_ctrl;
          dm_wdata = {24'h0, req_wdata[7:0]};
          dm_we    = req_we;
        end
      end
      SPLIT: begin
        stall    = 1'b1;
        dm_ctrl  = w_byte_ctrl;
        dm_addr  = req_addr + {30'h0, r_idx};
        dm_wdata = {24'h0, req_wdata[{r_idx, 3'b000} +: 8]};
        dm_we    = req_we;
      end
      DONE: begin
        dm_we = 1'b0;
        rdata = req_we ? 32'h0 : w_asm;
      end
      default: ;
    endcase
`endif
    // Reset must immediately quiesce the core handshake and the memory write strobe
    if (rst) begin
      stall = 1'b0;
      dm_we = 1'b0;
    end
  end

`ifndef MISALIGN_TRAP_EN
  logic [1:0] w_last;
  assign w_last = w_word ? 2'd3 : 2'd1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= 2'd0;
      r_buf   <= 32'h0;
      r_cnt   <= '0;
    end else begin
      if (w_mis && (r_state == IDLE) && (r_cnt != {CNT_W{1'b1}}))
        r_cnt <= r_cnt + 1'b1;
`ifndef MISALIGN_TRAP_EN
      case (r_state)
        IDLE: begin
          if (w_mis) begin
            if (!req_we) r_buf[7:0] <= dm_rdata[7:0];
            r_idx   <= 2'd1;
            r_state <= SPLIT;
          end
        end
        SPLIT: begin
          if (!req_we) r_buf[{r_idx, 3'b000} +: 8] <= dm_rdata[7:0];
          if (r_idx == w_last) begin
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_idx   <= 2'd0;
        end
        default: r_state <= IDLE;
      endcase
`endif
    end
  end

endmodule
